// File: rtl/ip_codma_bus_arbiter.sv
// CODMA memory bus arbiter: round-robin ownership between the read and
// write machines, bus request with grant timeout, and beat counting for
// the owner's burst. Event pulses and grants are all registered.
module ip_codma_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rd_req_i,
  input  logic [3:0] rd_size_i,
  output logic       rd_grant_o,
  output logic       rd_done_o,
  input  logic       wr_req_i,
  input  logic [3:0] wr_size_i,
  output logic       wr_grant_o,
  output logic       wr_done_o,
  input  logic       stop_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic [3:0] mem_size_o,
  input  logic       mem_grant_i,
  input  logic       mem_beat_i,
  input  logic       mem_error_i,
  output logic [1:0] beat_count_o,
  output logic       busy_o,
  output logic       error_o,
  output logic       timeout_o,
  output logic       size_err_o
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_XFER = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  // Size code 3/8/9 are the only legal burst sizes.
  function automatic logic f_size_legal(input logic [3:0] size);
    case (size)
      4'd3, 4'd8, 4'd9: f_size_legal = 1'b1;
      default:          f_size_legal = 1'b0;
    endcase
  endfunction

  // Index of the final beat (beat total minus one) for a size code.
  function automatic logic [1:0] f_last_beat(input logic [3:0] size);
    case (size)
      4'd3:    f_last_beat = 2'd0;
      4'd8:    f_last_beat = 2'd1;
      4'd9:    f_last_beat = 2'd3;
      default: f_last_beat = 2'd0;
    endcase
  endfunction

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic             r_last_wr, w_last_wr_nxt;
  logic             r_mem_write, w_mem_write_nxt;
  logic [3:0]       r_mem_size, w_mem_size_nxt;
  logic [1:0]       r_beat_cnt, w_beat_cnt_nxt;
  logic [1:0]       r_last_beat, w_last_beat_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic             w_error_nxt, w_timeout_nxt, w_size_err_nxt;
  logic             w_win_any, w_win_wr;
  logic [3:0]       w_win_size;
  logic             r_mem_req, r_rd_grant, r_wr_grant, r_rd_done, r_wr_done;
  logic             r_busy, r_error, r_timeout, r_size_err;

  // Round-robin winner: on a tie the requester that did not own last wins.
  always_comb begin
    w_win_any  = rd_req_i | wr_req_i;
    w_win_wr   = wr_req_i & (~rd_req_i | ~r_last_wr);
    w_win_size = w_win_wr ? wr_size_i : rd_size_i;
  end

  // Next-state and next-value logic; stop beats bus error beats normal flow.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_wr_nxt   = r_last_wr;
    w_mem_write_nxt = r_mem_write;
    w_mem_size_nxt  = r_mem_size;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_last_beat_nxt = r_last_beat;
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_error_nxt     = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_size_err_nxt  = 1'b0;
    if (stop_i) begin
      // Abort returns everything to its quiet idle values.
      w_state_nxt     = ARB_IDLE;
      w_mem_write_nxt = 1'b0;
      w_mem_size_nxt  = 4'd0;
      w_beat_cnt_nxt  = 2'd0;
      w_tmo_cnt_nxt   = {TMO_W{1'b0}};
    end else if (mem_error_i && (r_state == ARB_REQ || r_state == ARB_XFER)) begin
      w_state_nxt = ARB_IDLE;
      w_error_nxt = 1'b1;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_win_any) begin
            w_mem_size_nxt  = w_win_size;
            w_mem_write_nxt = w_win_wr;
            if (f_size_legal(w_win_size)) begin
              w_last_wr_nxt   = w_win_wr;
              w_last_beat_nxt = f_last_beat(w_win_size);
              w_beat_cnt_nxt  = 2'd0;
              w_tmo_cnt_nxt   = {TMO_W{1'b0}};
              w_state_nxt     = ARB_REQ;
            end else begin
              w_size_err_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end
        ARB_REQ: begin
          if (mem_grant_i) begin
            w_beat_cnt_nxt = 2'd0;
            w_state_nxt    = ARB_XFER;
          end else if (r_tmo_cnt == TMO_LAST) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = ARB_IDLE;
          end else begin
            w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
          end
        end
        ARB_XFER: begin
          if (mem_beat_i) begin
            if (r_beat_cnt == r_last_beat) begin
              // Final beat: count holds so it stays visible through DONE.
              w_state_nxt = ARB_DONE;
            end else begin
              w_beat_cnt_nxt = r_beat_cnt + 2'd1;
            end
          end else begin
            w_beat_cnt_nxt = r_beat_cnt;
          end
        end
        ARB_DONE: begin
          w_state_nxt = ARB_IDLE;
        end
        default: begin
          w_state_nxt = ARB_IDLE;
        end
      endcase
    end
  end

  // State, bookkeeping and registered outputs derived from next values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ARB_IDLE;
      r_last_wr   <= 1'b1;
      r_mem_write <= 1'b0;
      r_mem_size  <= 4'd0;
      r_beat_cnt  <= 2'd0;
      r_last_beat <= 2'd0;
      r_tmo_cnt   <= {TMO_W{1'b0}};
      r_mem_req   <= 1'b0;
      r_rd_grant  <= 1'b0;
      r_wr_grant  <= 1'b0;
      r_rd_done   <= 1'b0;
      r_wr_done   <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
      r_timeout   <= 1'b0;
      r_size_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_wr   <= w_last_wr_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_size  <= w_mem_size_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_last_beat <= w_last_beat_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_mem_req   <= (w_state_nxt == ARB_REQ);
      r_rd_grant  <= (w_state_nxt == ARB_XFER) & ~w_mem_write_nxt;
      r_wr_grant  <= (w_state_nxt == ARB_XFER) &  w_mem_write_nxt;
      r_rd_done   <= (w_state_nxt == ARB_DONE) & ~w_mem_write_nxt;
      r_wr_done   <= (w_state_nxt == ARB_DONE) &  w_mem_write_nxt;
      r_busy      <= (w_state_nxt != ARB_IDLE);
      r_error     <= w_error_nxt;
      r_timeout   <= w_timeout_nxt;
      r_size_err  <= w_size_err_nxt;
    end
  end

  assign mem_req_o    = r_mem_req;
  assign mem_write_o  = r_mem_write;
  assign mem_size_o   = r_mem_size;
  assign rd_grant_o   = r_rd_grant;
  assign wr_grant_o   = r_wr_grant;
  assign rd_done_o    = r_rd_done;
  assign wr_done_o    = r_wr_done;
  assign beat_count_o = r_beat_cnt;
  assign busy_o       = r_busy;
  assign error_o      = r_error;
  assign timeout_o    = r_timeout;
  assign size_err_o   = r_size_err;

endmodule
